hex_display_ctrl: RTL and testbench
===================================

// Module: hex_display_ctrl
// PURPOSE
//  Upstream feeder for the per-digit hex7seg decoders on the board HEX displays.
//  Captures one of NUM_SRC 32-bit pipeline debug words (PC, instr, ALU, WB) and registers its low nibbles.
//  Cycles the selected source on a debounced push-button; freeze switch holds the shown value.
//  Emits one nibble plus one blank flag per digit to the downstream decoders.
// PARAMETERS
//  N_DIGITS        8       digits driven; legal 1..8; shows low N_DIGITS*4 bits of the word
//  NUM_SRC         4       debug sources; legal 2..16
//  DEBOUNCE_CYCLES 500000  consecutive stable samples to accept a key level (10 ms @ 50 MHz)
// PORTS
//  iCLK        in   1                clock
//  iRST        in   1                asynchronous, active-high reset
//  iSRC_DATA   in   NUM_SRC*32       flattened sources; source k = bits [32k+31:32k]
//  iCAPTURE    in   1                sample strobe from the pipeline (e.g. instruction retire)
//  iFREEZE     in   1                level; 1 = ignore iCAPTURE
//  iKEY_NEXT   in   1                raw board key, active-low, asynchronous to iCLK
//  oDIGIT      out  N_DIGITS*4       nibble per digit; digit 0 = bits [3:0] (least significant)
//  oBLANK      out  N_DIGITS         1 = downstream must drive that display all-off
//  oSRC_SEL    out  $clog2(NUM_SRC)  currently selected source index
//  oUPDATED    out  1                one-cycle pulse when oDIGIT/oBLANK were reloaded
// BEHAVIOUR
//  Reset (async assert, sync release): oSRC_SEL=0, oDIGIT=0, oUPDATED=0, debouncer in IDLE with accepted level=1.
//   oBLANK at reset: with LZ_BLANK_EN all bits 1 except bit 0; otherwise all 0.
//  Key path: 2-FF synchroniser, then key_debounce FSM on the synchronised level:
//   IDLE: accepted=1; sample=0 -> PRESS_WAIT, count cleared
//   PRESS_WAIT: sample=1 -> IDLE; count reaches DEBOUNCE_CYCLES-1 -> PRESSED, emit 1-cycle press pulse
//   PRESSED: sample=1 -> RELEASE_WAIT, count cleared
//   RELEASE_WAIT: sample=0 -> PRESSED; count reaches DEBOUNCE_CYCLES-1 -> IDLE
//   Any glitch shorter than DEBOUNCE_CYCLES is ignored; holding the key gives exactly one pulse.
//  Press pulse: oSRC_SEL <= (oSRC_SEL==NUM_SRC-1) ? 0 : oSRC_SEL+1; wraps to 0.
//  Load rule, evaluated each cycle:
//   press pulse -> next cycle load the new source's current data; applies even when iFREEZE=1.
//   else iCAPTURE && !iFREEZE -> load the selected source.
//   Press and capture in the same cycle -> one load only, from the new source.
//  Latency: load condition sampled at edge N; oDIGIT, oBLANK and oUPDATED valid after edge N+1.
//   Press pulse -> oSRC_SEL updates at N+1; data at N+2.
//   All three outputs are registered; no combinational path from inputs to outputs.
//  oUPDATED: high exactly one cycle per load; stays high on back-to-back captures.
//  Reset mid-debounce: the FSM returns to IDLE; a key still held after reset needs a full debounce and gives one pulse.
// CONFIGURATION
//  LZ_BLANK_EN defined: leading-zero blanking.
//   oBLANK[i]=1 iff i>0 and digits N_DIGITS-1..i of the loaded word are all zero; digit 0 is never blanked.
//   Computed from the value being loaded and registered with it.
//  LZ_BLANK_EN undefined: oBLANK tied to 0 and the blanking logic is absent.
// STRUCTURE
//  Package hex_disp_pkg:
//   typedef enum {DB_IDLE, DB_PRESS_WAIT, DB_PRESSED, DB_RELEASE_WAIT} db_state_t
//   localparams SRC_PC=0, SRC_INSTR=1, SRC_ALU=2, SRC_WB=3; DIGIT_W=4
//  Sub-module key_debounce (parameter DEBOUNCE_CYCLES): synchroniser + FSM; outputs a press pulse.
//  Top: source mux, select counter, capture/blank registers.
// TESTING (sim with DEBOUNCE_CYCLES=4, N_DIGITS=8, NUM_SRC=4, LZ_BLANK_EN defined)
//  1 Reset: assert iRST mid-run -> immediately oSRC_SEL=0, oDIGIT=0, oBLANK=8'hFE, oUPDATED=0.
//  2 Capture: src0=32'h0000_1A2C, pulse iCAPTURE -> next cycle oDIGIT=32'h0000_1A2C, oBLANK=8'hF0, oUPDATED 1 cycle.
//  3 Freeze: iFREEZE=1, src0=32'hDEAD_BEEF, iCAPTURE -> oDIGIT unchanged, oUPDATED=0.
//  4 Debounce: key low 2 cycles then high -> no select change.
//    Key low 20 cycles -> oSRC_SEL 0->1 once; src1=32'h8000_0000 loaded, oBLANK=8'h00.
//  5 Wrap/simultaneous: from sel=3, press while iCAPTURE=1 -> oSRC_SEL=0, single load of src0, one oUPDATED pulse.
//  6 Zero word: capture 32'h0 -> oDIGIT=0, oBLANK=8'hFE.
//    Rebuild without LZ_BLANK_EN -> oBLANK=0 throughout.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the HEX display controller.
//   db_state_t : key debouncer FSM states
//   SRC_*      : conventional source indices on iSRC_DATA
//   DIGIT_W    : bits per displayed digit
package hex_disp_pkg;

    localparam int unsigned DIGIT_W   = 4;

    localparam int unsigned SRC_PC    = 0;
    localparam int unsigned SRC_INSTR = 1;
    localparam int unsigned SRC_ALU   = 2;
    localparam int unsigned SRC_WB    = 3;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS_WAIT,
        DB_PRESSED,
        DB_RELEASE_WAIT
    } db_state_t;

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one active-low board push-button.
// A 2-FF synchroniser feeds a four-state FSM that accepts a new key level only
// after DEBOUNCE_CYCLES consecutive stable samples, and emits a single-cycle
// pulse when a press is accepted.
// Ports:
//   clk_i    clock
//   rst_i    asynchronous active-high reset (FSM -> DB_IDLE, accepted level = 1)
//   key_n_i  raw key, active-low, asynchronous to clk_i
//   press_o  one-cycle pulse per accepted press
module key_debounce
    import hex_disp_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sample;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Reset to 1 so an idle (released) key looks stable from the first cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
        end
    end

    assign sample = sync_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_o = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (!sample) begin
                    state_d = DB_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            DB_PRESS_WAIT: begin
                if (sample) begin
                    state_d = DB_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_PRESSED;
                    press_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DB_PRESSED: begin
                if (sample) begin
                    state_d = DB_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            DB_RELEASE_WAIT: begin
                if (!sample) begin
                    state_d = DB_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = DB_IDLE;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Feeder for the per-digit hex7seg decoders on the board HEX displays.
// Selects one of NUM_SRC 32-bit debug words, registers its low N_DIGITS nibbles
// on a capture strobe (unless frozen) and steps the selection on a debounced key.
// Build option: define LZ_BLANK_EN for leading-zero blanking; otherwise oBLANK = 0.
// Ports:
//   iCLK       clock
//   iRST       asynchronous active-high reset (released synchronously inside)
//   iSRC_DATA  flattened sources, source k = bits [32k+31:32k]
//   iCAPTURE   sample strobe from the pipeline
//   iFREEZE    1 = ignore iCAPTURE
//   iKEY_NEXT  raw active-low key, selects the next source
//   oDIGIT     nibble per digit, digit 0 = bits [3:0]
//   oBLANK     1 = downstream drives that display all-off
//   oSRC_SEL   selected source index
//   oUPDATED   one-cycle pulse when oDIGIT/oBLANK were reloaded
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int unsigned N_DIGITS        = 8,
    parameter int unsigned NUM_SRC         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic [NUM_SRC*32-1:0]      iSRC_DATA,
    input  logic                       iCAPTURE,
    input  logic                       iFREEZE,
    input  logic                       iKEY_NEXT,
    output logic [N_DIGITS*DIGIT_W-1:0] oDIGIT,
    output logic [N_DIGITS-1:0]        oBLANK,
    output logic [$clog2(NUM_SRC)-1:0] oSRC_SEL,
    output logic                       oUPDATED
);

    localparam int unsigned      SEL_W   = $clog2(NUM_SRC);
    localparam int unsigned      DISP_W  = N_DIGITS * DIGIT_W;
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_SRC - 1);

    logic [1:0]        rst_sync_q;
    logic              rst;
    logic              press;
    logic [SEL_W-1:0]  sel_q;
    logic              load_pend_q;
    logic              load;
    logic [DISP_W-1:0] src_low;
    logic [DISP_W-1:0] digit_q;
    logic              upd_q;

    // Assert immediately, release two clocks after iRST drops.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst = rst_sync_q[1];

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk_i  (iCLK),
        .rst_i  (rst),
        .key_n_i(iKEY_NEXT),
        .press_o(press)
    );

    // A press defers its load by one cycle so it reads the newly selected
    // source; a capture in the press cycle is absorbed into that single load.
    assign load = load_pend_q | (iCAPTURE & ~iFREEZE & ~press);

    always_comb begin
        src_low = iSRC_DATA[int'(sel_q) * 32 +: DISP_W];
    end

    always_ff @(posedge iCLK or posedge rst) begin
        if (rst) begin
            sel_q       <= '0;
            load_pend_q <= 1'b0;
            digit_q     <= '0;
            upd_q       <= 1'b0;
        end else begin
            load_pend_q <= press;
            upd_q       <= load;
            if (press) begin
                sel_q <= (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
            end
            if (load) begin
                digit_q <= src_low;
            end
        end
    end

`ifdef LZ_BLANK_EN
    localparam logic [N_DIGITS-1:0] BLANK_RST = ~N_DIGITS'(1);

    logic [N_DIGITS-1:0] blank_d;
    logic [N_DIGITS-1:0] blank_q;
    logic                all_zero;

    // Walk down from the top digit; a digit blanks while everything above it
    // (inclusive) is zero. Digit 0 always shows.
    always_comb begin
        blank_d  = '0;
        all_zero = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            all_zero   = all_zero & (src_low[i*DIGIT_W +: DIGIT_W] == '0);
            blank_d[i] = all_zero;
        end
    end

    always_ff @(posedge iCLK or posedge rst) begin
        if (rst) begin
            blank_q <= BLANK_RST;
        end else if (load) begin
            blank_q <= blank_d;
        end
    end

    assign oBLANK = blank_q;
`else
    assign oBLANK = '0;
`endif

    assign oDIGIT   = digit_q;
    assign oSRC_SEL = sel_q;
    assign oUPDATED = upd_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl (N_DIGITS=8, NUM_SRC=4, DEBOUNCE_CYCLES=4).
module tb_hex_display_ctrl;

    localparam int unsigned N_DIG = 8;
    localparam int unsigned N_SRC = 4;
    localparam int unsigned DB    = 4;
`ifdef LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_SRC*32-1:0]   src_data;
    logic                  cap;
    logic                  frz;
    logic                  key;
    logic [N_DIG*4-1:0]    digit;
    logic [N_DIG-1:0]      blank;
    logic [1:0]            sel;
    logic                  upd;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_digit;
    logic [1:0]  exp_sel;

    hex_display_ctrl #(
        .N_DIGITS       (N_DIG),
        .NUM_SRC        (N_SRC),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iSRC_DATA(src_data),
        .iCAPTURE (cap),
        .iFREEZE  (frz),
        .iKEY_NEXT(key),
        .oDIGIT   (digit),
        .oBLANK   (blank),
        .oSRC_SEL (sel),
        .oUPDATED (upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    // Blank every digit above the highest non-zero one (digit 0 never blanks).
    function automatic logic [7:0] ref_blank(input logic [31:0] w);
        int h = 0;
        logic [7:0] b = '0;
        for (int i = 0; i < 8; i++) if (((w >> (4 * i)) & 32'hF) != 0) h = i;
        for (int i = 1; i < 8; i++) b[i] = (i > h);
        return LZ ? b : 8'h00;
    endfunction

    task automatic set_src(input int k, input logic [31:0] w);
        src_data[32*k +: 32] = w;
    endtask

    // Key low for low_n cycles then high for high_n. Optionally pulse iCAPTURE
    // before edge cap_edge. Reports edge index of first select change and of last update.
    task automatic press_seq(input int low_n, input int high_n, input int cap_edge,
                             output int sel_edge, output int upd_edge, output int n_upd,
                             output int n_sel_chg);
        logic [1:0] prev;
        prev      = sel;
        sel_edge  = -1;
        upd_edge  = -1;
        n_upd     = 0;
        n_sel_chg = 0;
        for (int i = 1; i <= low_n + high_n; i++) begin
            key = (i <= low_n) ? 1'b0 : 1'b1;
            cap = (i == cap_edge);
            @(negedge clk);
            if (sel !== prev) begin
                n_sel_chg++;
                if (sel_edge < 0) sel_edge = i;
                prev = sel;
            end
            if (upd === 1'b1) begin
                n_upd++;
                upd_edge = i;
            end
        end
        cap = 1'b0;
        key = 1'b1;
    endtask

    task automatic rand_run(input int n);
        logic [31:0] w;
        int sh;
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < int'(N_SRC); k++) begin
                w  = $urandom;
                sh = $urandom_range(0, 8) * 4;
                set_src(k, (sh == 32) ? 32'h0 : (w >> sh));
            end
            cap = $urandom_range(0, 1) == 1;
            frz = $urandom_range(0, 3) == 0;
            @(negedge clk);
            if (cap && !frz) exp_digit = src_data[32*exp_sel +: 32];
            check("rand_digit", digit, exp_digit);
            check("rand_blank", blank, ref_blank(exp_digit));
            check("rand_upd", upd, (cap && !frz) ? 1 : 0);
        end
        cap = 1'b0;
        frz = 1'b0;
    endtask

    typedef struct {
        logic [31:0] src0;
        bit          cap;
        bit          frz;
        logic [31:0] exp_digit;
        logic [7:0]  exp_blank;  // value with leading-zero blanking on
        bit          exp_upd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int sel_edge, upd_edge, n_upd, n_chg, k_press;

        vecs[0] = '{32'h0000_1A2C, 1, 0, 32'h0000_1A2C, 8'hF0, 1};
        vecs[1] = '{32'hDEAD_BEEF, 1, 1, 32'h0000_1A2C, 8'hF0, 0};
        vecs[2] = '{32'hDEAD_BEEF, 0, 0, 32'h0000_1A2C, 8'hF0, 0};
        vecs[3] = '{32'h1234_5678, 1, 0, 32'h1234_5678, 8'h00, 1};
        vecs[4] = '{32'h0000_00F0, 1, 0, 32'h0000_00F0, 8'hFC, 1};
        vecs[5] = '{32'h0000_0000, 1, 0, 32'h0000_0000, 8'hFE, 1};
        vecs[6] = '{32'h0ABC_DEF0, 1, 1, 32'h0000_0000, 8'hFE, 0};
        vecs[7] = '{32'h0ABC_DEF0, 1, 0, 32'h0ABC_DEF0, 8'h80, 1};

        rst      = 1'b1;
        src_data = '0;
        cap      = 1'b0;
        frz      = 1'b0;
        key      = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Load something, then reset mid-cycle while oUPDATED is high.
        set_src(0, 32'h5555_1234);
        cap = 1'b1;
        @(negedge clk);
        check("pre_rst_upd", upd, 1);
        check("pre_rst_digit", digit, 32'h5555_1234);
        cap = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_sel", sel, 0);
        check("rst_digit", digit, 0);
        check("rst_blank", blank, LZ ? 8'hFE : 8'h00);
        check("rst_upd", upd, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        foreach (vecs[i]) begin
            set_src(0, vecs[i].src0);
            cap = vecs[i].cap;
            frz = vecs[i].frz;
            @(negedge clk);
            check($sformatf("vec%0d_digit", i), digit, vecs[i].exp_digit);
            check($sformatf("vec%0d_blank", i), blank, LZ ? vecs[i].exp_blank : 8'h00);
            check($sformatf("vec%0d_upd", i), upd, vecs[i].exp_upd);
        end
        cap = 1'b0;
        frz = 1'b0;

        // Short glitch: no select change, no load.
        set_src(1, 32'h8000_0000);
        press_seq(2, 15, -1, sel_edge, upd_edge, n_upd, n_chg);
        check("glitch_sel_chg", n_chg, 0);
        check("glitch_upd", n_upd, 0);
        check("glitch_sel", sel, 0);

        // Long press: exactly one step and one load of the new source.
        press_seq(20, 20, -1, sel_edge, upd_edge, n_upd, n_chg);
        k_press = sel_edge;
        check("press1_sel_chg", n_chg, 1);
        check("press1_sel", sel, 1);
        check("press1_upd", n_upd, 1);
        check("press1_lat", upd_edge - sel_edge, 1);
        check("press1_digit", digit, 32'h8000_0000);
        check("press1_blank", blank, 8'h00);

        set_src(2, 32'h0000_0077);
        press_seq(20, 20, -1, sel_edge, upd_edge, n_upd, n_chg);
        check("press2_sel", sel, 2);
        check("press2_digit", digit, 32'h0000_0077);
        check("press2_blank", blank, ref_blank(32'h0000_0077));
        set_src(3, 32'h0003_0000);
        press_seq(20, 20, -1, sel_edge, upd_edge, n_upd, n_chg);
        check("press3_sel", sel, 3);
        check("press3_digit", digit, 32'h0003_0000);

        // Wrap with a capture on the very edge the press is taken.
        set_src(0, 32'h0000_0ABC);
        press_seq(20, 20, k_press, sel_edge, upd_edge, n_upd, n_chg);
        check("wrap_sel", sel, 0);
        check("wrap_upd_count", n_upd, 1);
        check("wrap_lat", upd_edge - sel_edge, 1);
        check("wrap_digit", digit, 32'h0000_0ABC);
        check("wrap_blank", blank, LZ ? 8'hF8 : 8'h00);

        // Freeze does not block a press-triggered load.
        frz = 1'b1;
        set_src(1, 32'h00C0_FFEE);
        press_seq(20, 20, -1, sel_edge, upd_edge, n_upd, n_chg);
        frz = 1'b0;
        check("frz_press_sel", sel, 1);
        check("frz_press_upd", n_upd, 1);
        check("frz_press_digit", digit, 32'h00C0_FFEE);

        exp_sel   = 2'd1;
        exp_digit = 32'h00C0_FFEE;
        rand_run(150);
        press_seq(20, 20, -1, sel_edge, upd_edge, n_upd, n_chg);
        exp_sel   = 2'd2;
        exp_digit = src_data[32*exp_sel +: 32];
        check("rand_press_sel", sel, exp_sel);
        check("rand_press_digit", digit, exp_digit);
        rand_run(150);

        #2 rst = 1'b1;
        #1;
        check("rst2_sel", sel, 0);
        check("rst2_blank", blank, LZ ? 8'hFE : 8'h00);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
